// File: rtl/tl_frag_resp_merger.sv
// tl_frag_resp_merger: collapses the D-channel responses of a fragmented
// TileLink request back into the response the original master expects.
// A per-source table, loaded through the track port, counts the beats still
// due for each fragmented request. Non-final AccessAck beats are swallowed,
// data beats pass through, and every beat that hits a tracked source reports
// the original lgSize. The data path is purely combinational (zero latency).
//
// Optional feature macro: TL_FRAG_DENIED_STICKY_EN
//   defined   - denied bits of non-final beats are accumulated and OR-ed into
//               the denied bit of the final beat.
//   undefined - denied passes through unchanged; no accumulator exists.
module tl_frag_resp_merger (
  input  logic         clock,
  input  logic         reset,

  input  logic         io_track_valid,
  output logic         io_track_ready,
  input  logic [3:0]   io_track_source,
  input  logic [4:0]   io_track_frags,
  input  logic [3:0]   io_track_size,

  input  logic         io_in_valid,
  output logic         io_in_ready,
  input  logic [2:0]   io_in_bits_opcode,
  input  logic [1:0]   io_in_bits_param,
  input  logic [3:0]   io_in_bits_size,
  input  logic [3:0]   io_in_bits_source,
  input  logic         io_in_bits_denied,
  input  logic         io_in_bits_corrupt,
  input  logic [127:0] io_in_bits_data,

  input  logic         io_out_ready,
  output logic         io_out_valid,
  output logic [2:0]   io_out_bits_opcode,
  output logic [1:0]   io_out_bits_param,
  output logic [3:0]   io_out_bits_size,
  output logic [3:0]   io_out_bits_source,
  output logic         io_out_bits_denied,
  output logic         io_out_bits_corrupt,
  output logic [127:0] io_out_bits_data
);

  localparam int unsigned NUM_SRC  = 16;
  localparam int unsigned FRAG_W   = 5;
  localparam int unsigned SIZE_W   = 4;
  localparam logic [2:0]  OP_ACCESS_ACK = 3'd0;

  // Per-source tracking table
  logic [NUM_SRC-1:0] r_busy;
  logic [FRAG_W-1:0]  r_remaining [NUM_SRC];
  logic [SIZE_W-1:0]  r_size      [NUM_SRC];

  logic w_track_fire;
  logic w_hit;
  logic w_last;
  logic w_drop;
  logic w_in_fire;

  // Beat classification against the table entry of the beat's source
  assign w_hit  = io_in_valid & r_busy[io_in_bits_source];
  assign w_last = w_hit & (r_remaining[io_in_bits_source] == FRAG_W'(0));
  assign w_drop = w_hit & ~w_last & (io_in_bits_opcode == OP_ACCESS_ACK);

  // Handshakes: swallowed acks are consumed regardless of the upstream
  assign io_track_ready = ~r_busy[io_track_source];
  assign w_track_fire   = io_track_valid & io_track_ready;
  assign io_out_valid   = io_in_valid & ~w_drop;
  assign io_in_ready    = io_out_ready | w_drop;
  assign w_in_fire      = io_in_valid & io_in_ready;

  // Payload pass-through with original size restored on tracked sources
  assign io_out_bits_opcode  = io_in_bits_opcode;
  assign io_out_bits_param   = io_in_bits_param;
  assign io_out_bits_source  = io_in_bits_source;
  assign io_out_bits_corrupt = io_in_bits_corrupt;
  assign io_out_bits_data    = io_in_bits_data;
  assign io_out_bits_size    = w_hit ? r_size[io_in_bits_source] : io_in_bits_size;

`ifdef TL_FRAG_DENIED_STICKY_EN
  logic [NUM_SRC-1:0] r_denied_acc;

  // Final beat reports denial if any fragment was denied
  assign io_out_bits_denied = w_last ? (io_in_bits_denied | r_denied_acc[io_in_bits_source])
                                     : io_in_bits_denied;

  // Denial accumulator: cleared on registration, OR-ed on non-final beats
  always_ff @(posedge clock) begin
    if (!reset) begin
      if (w_track_fire) begin
        r_denied_acc[io_track_source] <= 1'b0;
      end
      if (w_in_fire && w_hit && !w_last) begin
        r_denied_acc[io_in_bits_source] <= r_denied_acc[io_in_bits_source] | io_in_bits_denied;
      end
    end
  end
`else
  assign io_out_bits_denied = io_in_bits_denied;
`endif

  // Busy bits: set on registration, cleared when the final beat is accepted.
  // A tracked source is never registrable, so set and clear never collide.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_busy <= '0;
    end else begin
      if (w_track_fire) begin
        r_busy[io_track_source] <= 1'b1;
      end
      if (w_in_fire && w_last) begin
        r_busy[io_in_bits_source] <= 1'b0;
      end
    end
  end

  // Beat counter and original size; contents are meaningless while not busy
  always_ff @(posedge clock) begin
    if (!reset) begin
      if (w_track_fire) begin
        r_remaining[io_track_source] <= io_track_frags;
        r_size[io_track_source]      <= io_track_size;
      end
      if (w_in_fire && w_hit && !w_last) begin
        r_remaining[io_in_bits_source] <= r_remaining[io_in_bits_source] - FRAG_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_tl_frag_resp_merger.sv
// Bench for tl_frag_resp_merger: directed vector table, a reset-mid-merge
// sequence, then randomized traffic checked against a beat-count model.
module tb_tl_frag_resp_merger;

`ifdef TL_FRAG_DENIED_STICKY_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  logic         clock = 1'b0;
  logic         reset;
  logic         io_track_valid;
  logic         io_track_ready;
  logic [3:0]   io_track_source;
  logic [4:0]   io_track_frags;
  logic [3:0]   io_track_size;
  logic         io_in_valid;
  logic         io_in_ready;
  logic [2:0]   io_in_bits_opcode;
  logic [1:0]   io_in_bits_param;
  logic [3:0]   io_in_bits_size;
  logic [3:0]   io_in_bits_source;
  logic         io_in_bits_denied;
  logic         io_in_bits_corrupt;
  logic [127:0] io_in_bits_data;
  logic         io_out_ready;
  logic         io_out_valid;
  logic [2:0]   io_out_bits_opcode;
  logic [1:0]   io_out_bits_param;
  logic [3:0]   io_out_bits_size;
  logic [3:0]   io_out_bits_source;
  logic         io_out_bits_denied;
  logic         io_out_bits_corrupt;
  logic [127:0] io_out_bits_data;

  tl_frag_resp_merger dut (
    .clock(clock), .reset(reset),
    .io_track_valid(io_track_valid), .io_track_ready(io_track_ready),
    .io_track_source(io_track_source), .io_track_frags(io_track_frags),
    .io_track_size(io_track_size),
    .io_in_valid(io_in_valid), .io_in_ready(io_in_ready),
    .io_in_bits_opcode(io_in_bits_opcode), .io_in_bits_param(io_in_bits_param),
    .io_in_bits_size(io_in_bits_size), .io_in_bits_source(io_in_bits_source),
    .io_in_bits_denied(io_in_bits_denied), .io_in_bits_corrupt(io_in_bits_corrupt),
    .io_in_bits_data(io_in_bits_data),
    .io_out_ready(io_out_ready), .io_out_valid(io_out_valid),
    .io_out_bits_opcode(io_out_bits_opcode), .io_out_bits_param(io_out_bits_param),
    .io_out_bits_size(io_out_bits_size), .io_out_bits_source(io_out_bits_source),
    .io_out_bits_denied(io_out_bits_denied), .io_out_bits_corrupt(io_out_bits_corrupt),
    .io_out_bits_data(io_out_bits_data)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    logic       tv;  logic [3:0] ts; logic [4:0] tf; logic [3:0] tz;
    logic       iv;  logic [2:0] op; logic [3:0] src; logic [3:0] isz;
    logic       den; logic       ordy;
    logic       e_tr; logic e_ir; logic e_ov; logic [3:0] e_sz; logic e_den;
  } vec_t;

  function automatic vec_t mk(logic tv, logic [3:0] ts, logic [4:0] tf, logic [3:0] tz,
                              logic iv, logic [2:0] op, logic [3:0] src, logic [3:0] isz,
                              logic den, logic ordy, logic e_tr, logic e_ir, logic e_ov,
                              logic [3:0] e_sz, logic e_den);
    vec_t v;
    v.tv = tv; v.ts = ts; v.tf = tf; v.tz = tz; v.iv = iv; v.op = op; v.src = src;
    v.isz = isz; v.den = den; v.ordy = ordy; v.e_tr = e_tr; v.e_ir = e_ir;
    v.e_ov = e_ov; v.e_sz = e_sz; v.e_den = e_den;
    return v;
  endfunction

  task automatic drive(logic tv, logic [3:0] ts, logic [4:0] tf, logic [3:0] tz,
                       logic iv, logic [2:0] op, logic [3:0] src, logic [3:0] isz,
                       logic den, logic ordy);
    io_track_valid     = tv;
    io_track_source    = ts;
    io_track_frags     = tf;
    io_track_size      = tz;
    io_in_valid        = iv;
    io_in_bits_opcode  = op;
    io_in_bits_source  = src;
    io_in_bits_size    = isz;
    io_in_bits_denied  = den;
    io_out_ready       = ordy;
    io_in_bits_param   = 2'($urandom_range(0, 3));
    io_in_bits_corrupt = 1'($urandom_range(0, 1));
    io_in_bits_data    = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic check_passthru(input string tag);
    check({tag, ".opcode"}, 128'(io_out_bits_opcode), 128'(io_in_bits_opcode));
    check({tag, ".param"},  128'(io_out_bits_param),  128'(io_in_bits_param));
    check({tag, ".source"}, 128'(io_out_bits_source), 128'(io_in_bits_source));
    check({tag, ".corrupt"},128'(io_out_bits_corrupt),128'(io_in_bits_corrupt));
    check({tag, ".data"},   io_out_bits_data,         io_in_bits_data);
  endtask

  // Reference model: beats still owed per source (0 = idle)
  int         m_left [16];
  logic [3:0] m_size [16];
  logic       m_dacc [16];

  vec_t vecs [26];

  initial begin
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;

    // Directed table; rows execute back to back, state carries across rows
    vecs[0]  = mk(0,0,0,0, 0,0,0,0,0,1, 1,1,0,0,0);
    vecs[1]  = mk(1,3,3,6, 0,0,0,0,0,1, 1,1,0,0,0);
    vecs[2]  = mk(0,3,0,0, 1,0,3,3,0,1, 0,1,0,6,0);
    vecs[3]  = mk(0,3,0,0, 1,0,3,3,0,1, 0,1,0,6,0);
    vecs[4]  = mk(0,3,0,0, 1,0,3,3,0,1, 0,1,0,6,0);
    vecs[5]  = mk(0,3,0,0, 1,0,3,3,0,1, 0,1,1,6,0);
    vecs[6]  = mk(0,3,0,0, 0,0,0,0,0,1, 1,1,0,0,0);
    vecs[7]  = mk(1,5,1,5, 0,0,0,0,0,1, 1,1,0,0,0);
    vecs[8]  = mk(0,5,0,0, 1,1,5,4,0,1, 0,1,1,5,0);
    vecs[9]  = mk(0,5,0,0, 1,1,5,4,0,1, 0,1,1,5,0);
    vecs[10] = mk(0,5,0,0, 0,0,0,0,0,1, 1,1,0,0,0);
    vecs[11] = mk(1,7,2,2, 0,0,0,0,0,1, 1,1,0,0,0);
    vecs[12] = mk(0,7,0,0, 1,1,7,1,0,0, 0,0,1,2,0);
    vecs[13] = mk(0,7,0,0, 1,0,7,1,0,0, 0,1,0,2,0);
    vecs[14] = mk(0,7,0,0, 1,1,7,1,0,1, 0,1,1,2,0);
    vecs[15] = mk(0,7,0,0, 1,1,7,1,0,1, 0,1,1,2,0);
    vecs[16] = mk(0,7,0,0, 0,0,0,0,0,1, 1,1,0,0,0);
    vecs[17] = mk(1,2,0,7, 0,0,0,0,0,1, 1,1,0,0,0);
    vecs[18] = mk(1,2,0,4, 1,1,2,3,0,1, 0,1,1,7,0);
    vecs[19] = mk(1,2,0,4, 0,0,0,0,0,1, 1,1,0,0,0);
    vecs[20] = mk(0,2,0,0, 1,0,2,1,0,1, 0,1,1,4,0);
    vecs[21] = mk(1,9,2,6, 0,0,0,0,0,1, 1,1,0,0,0);
    vecs[22] = mk(0,9,0,0, 1,1,9,4,0,1, 0,1,1,6,0);
    vecs[23] = mk(0,9,0,0, 1,1,9,4,1,1, 0,1,1,6,1);
    vecs[24] = mk(0,9,0,0, 1,1,9,4,0,1, 0,1,1,6,STICKY);
    vecs[25] = mk(0,11,0,0, 1,4,11,9,1,0, 1,0,1,9,1);

    for (int i = 0; i < 26; i++) begin
      drive(vecs[i].tv, vecs[i].ts, vecs[i].tf, vecs[i].tz, vecs[i].iv, vecs[i].op,
            vecs[i].src, vecs[i].isz, vecs[i].den, vecs[i].ordy);
      #1;
      check($sformatf("vec%0d.track_ready", i), 128'(io_track_ready), 128'(vecs[i].e_tr));
      check($sformatf("vec%0d.in_ready", i),    128'(io_in_ready),    128'(vecs[i].e_ir));
      check($sformatf("vec%0d.out_valid", i),   128'(io_out_valid),   128'(vecs[i].e_ov));
      check($sformatf("vec%0d.size", i),        128'(io_out_bits_size), 128'(vecs[i].e_sz));
      check($sformatf("vec%0d.denied", i),      128'(io_out_bits_denied), 128'(vecs[i].e_den));
      check_passthru($sformatf("vec%0d", i));
      @(negedge clock);
    end

    // Reset in the middle of a four-beat merge abandons it
    drive(1, 3, 3, 6, 0, 0, 0, 0, 0, 1);
    @(negedge clock);
    for (int i = 0; i < 2; i++) begin
      drive(0, 3, 0, 0, 1, 0, 3, 2, 0, 1);
      #1;
      check("rst_seq.drop_valid", 128'(io_out_valid), 128'(0));
      @(negedge clock);
    end
    drive(0, 3, 0, 0, 0, 0, 0, 0, 0, 1);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    drive(0, 3, 0, 0, 1, 0, 3, 2, 0, 1);
    #1;
    check("rst_seq.track_ready", 128'(io_track_ready), 128'(1));
    check("rst_seq.out_valid",   128'(io_out_valid),   128'(1));
    check("rst_seq.in_ready",    128'(io_in_ready),    128'(1));
    check("rst_seq.size",        128'(io_out_bits_size), 128'(2));
    @(negedge clock);

    // Randomized traffic against the beat-count model
    for (int s = 0; s < 16; s++) begin
      m_left[s] = 0; m_size[s] = '0; m_dacc[s] = 1'b0;
    end
    for (int cyc = 0; cyc < 4000; cyc++) begin
      logic do_rst, hit, last, drop, fire, e_den;
      logic [3:0] e_sz;
      int ts, src;
      do_rst = ($urandom_range(0, 299) == 0);
      drive(1'($urandom_range(0, 1)), 4'($urandom_range(0, 5)), 5'($urandom_range(0, 4)),
            4'($urandom), 1'($urandom_range(0, 9) < 7),
            ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 1)) : 3'($urandom),
            4'($urandom_range(0, 5)), 4'($urandom), 1'($urandom_range(0, 3) == 0),
            1'($urandom_range(0, 3) != 0));
      reset = do_rst;
      ts  = int'(io_track_source);
      src = int'(io_in_bits_source);
      hit  = io_in_valid && (m_left[src] > 0);
      last = hit && (m_left[src] == 1);
      drop = hit && !last && (io_in_bits_opcode == 3'd0);
      fire = io_in_valid && (io_out_ready || drop);
      e_sz = hit ? m_size[src] : io_in_bits_size;
      e_den = (STICKY && last) ? (io_in_bits_denied | m_dacc[src]) : io_in_bits_denied;
      #1;
      check("rnd.track_ready", 128'(io_track_ready), 128'(m_left[ts] == 0));
      check("rnd.in_ready",    128'(io_in_ready),    128'(io_out_ready || drop));
      check("rnd.out_valid",   128'(io_out_valid),   128'(io_in_valid && !drop));
      check("rnd.size",        128'(io_out_bits_size), 128'(e_sz));
      check("rnd.denied",      128'(io_out_bits_denied), 128'(e_den));
      check_passthru("rnd");
      // Model state advance at the coming clock edge
      if (do_rst) begin
        for (int s = 0; s < 16; s++) m_left[s] = 0;
      end else begin
        if (fire && hit) begin
          m_left[src] = m_left[src] - 1;
          if (!last) m_dacc[src] = m_dacc[src] | io_in_bits_denied;
        end
        if (io_track_valid && io_track_ready) begin
          m_left[ts] = int'(io_track_frags) + 1;
          m_size[ts] = io_track_size;
          m_dacc[ts] = 1'b0;
        end
      end
      @(negedge clock);
      reset = 1'b0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tl_frag_resp_merger.md
TL_FRAG_RESP_MERGER -- requirements
Module: tl_frag_resp_merger

Interface
REQ-001 SHALL provide one clock and a synchronous, active-high reset: clock (input, 1, sole clock), then reset (input, 1, synchronous active-high).
REQ-002 SHALL provide io_track_valid (input, 1): fragmented-request registration strobe.
REQ-003 SHALL provide io_track_ready (output, 1): io_track_source entry idle.
REQ-004 SHALL provide io_track_source (input, 4): source ID of the fragmented request.
REQ-005 SHALL provide io_track_frags (input, 5): fragment count minus 1.
REQ-006 SHALL provide io_track_size (input, 4): original request lgSize.
REQ-007 SHALL provide io_in_valid (input, 1), io_in_ready (output, 1): D-channel handshake from downstream.
REQ-008 SHALL provide io_in_bits_opcode (input, 3), _param (input, 2), _size (input, 4), _source (input, 4), _denied (input, 1), _corrupt (input, 1), _data (input, 128): D beat.
REQ-009 SHALL provide io_out_ready (input, 1), io_out_valid (output, 1): D-channel handshake to upstream.
REQ-010 SHALL provide io_out_bits_* (outputs): same fields and widths as io_in_bits_*.

Function
REQ-011 SHALL hold a 16-entry table indexed by source; each entry holds busy, remaining[4:0], size[3:0] and denied_acc.
REQ-012 SHALL drive io_track_ready = ~busy[io_track_source] combinationally.
REQ-013 SHALL, on io_track_valid & io_track_ready, set busy, remaining = io_track_frags, size = io_track_size and denied_acc = 0 for that source.
REQ-014 SHALL define hit = io_in_valid & busy[io_in_bits_source] and last = hit & (remaining == 0).
REQ-015 SHALL define drop = hit & ~last & (opcode == 0, AccessAck).
REQ-016 SHALL drive io_out_valid = io_in_valid & ~drop and io_in_ready = io_out_ready | drop; zero-cycle latency, no storage on the data path.
REQ-017 SHALL pass opcode, param, source, corrupt and data unchanged.
REQ-018 SHALL drive io_out_bits_size = table size on a hit, otherwise io_in_bits_size.
REQ-019 SHALL decrement remaining by 1 on each accepted non-last hit beat, dropped or passed.
REQ-020 SHALL clear busy on an accepted last beat.
REQ-021 SHALL pass a beat for a non-busy source fully unchanged and SHALL NOT change any table state.
REQ-022 SHALL, when the last beat of source S is accepted and track for S is presented in the same cycle, refuse the track that cycle (busy is registered) and accept it in the next cycle.
REQ-023 SHALL update entries for different sources independently in the same cycle.
REQ-024 SHALL never let remaining wrap below 0; a hit with remaining == 0 is always last.

Reset
REQ-025 SHALL, on reset, clear all busy bits; remaining, size and denied_acc are don't-care.
REQ-026 SHALL, after reset, drive io_track_ready = 1; io_out_valid equals io_in_valid and io_in_ready equals io_out_ready (pass-through).
REQ-027 SHALL abandon in-flight merges on reset mid-operation; subsequent beats pass unchanged.

Configuration
REQ-028 SHALL use macro TL_FRAG_DENIED_STICKY_EN; when defined, each accepted non-last hit sets denied_acc |= io_in_bits_denied, and a last beat outputs denied = io_in_bits_denied | denied_acc.
REQ-029 SHALL, when TL_FRAG_DENIED_STICKY_EN is undefined, pass denied unchanged and not implement denied_acc.

Verification
REQ-030 SHALL cover: track src 3, frags 3, size 6; four AccessAck beats src 3 -> first three accepted with out_valid 0, fourth emitted with size 6, busy[3] cleared.
REQ-031 SHALL cover: track src 5, frags 1, size 5; two AccessAckData beats size 4 -> both emitted with size 5, data unchanged, second clears busy.
REQ-032 SHALL cover: io_out_ready held 0 during a passing beat -> io_in_ready 0, no decrement; during a dropped ack -> io_in_ready 1, decrement.
REQ-033 SHALL cover: last beat src 2 accepted while track src 2 is presented -> io_track_ready 0 that cycle, 1 the next cycle.
REQ-034 SHALL cover: with TL_FRAG_DENIED_STICKY_EN, frags 2, denied 0,1,0 -> final beat denied 1; without the macro -> final beat denied 0.
REQ-035 SHALL cover: reset after the second of four beats -> busy 0, next AccessAck src 3 passes unchanged with its own size.
